// File: rtl/axi_cmd_traffic_gen.sv
// Command-port traffic generator: writes NUM_BURSTS bursts of a deterministic
// pattern, reads them back, counts mismatches/error responses and reports pass.
module axi_cmd_traffic_gen #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           NUM_BURSTS = 4,
  parameter int unsigned           MAX_LEN    = 3,
  parameter logic [DATA_WIDTH-1:0] SEED       = '0,
  parameter int unsigned           TIMEOUT    = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [1:0]              mode,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    timeout,
  output logic [15:0]             err_count,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic                    cmd_write,
  output logic [ADDR_WIDTH-1:0]   cmd_addr,
  output logic [7:0]              cmd_len,
  output logic                    cmd_wvalid,
  input  logic                    cmd_wready,
  output logic [DATA_WIDTH-1:0]   cmd_wdata,
  output logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  input  logic                    cmd_bvalid,
  input  logic                    cmd_rvalid,
  output logic                    cmd_rready,
  input  logic [DATA_WIDTH-1:0]   cmd_rdata,
  input  logic [1:0]              cmd_resp
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned TCW        = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] STRIDE   = ADDR_WIDTH'((MAX_LEN + 1) * STRB_WIDTH);
  localparam logic [8:0]            LAST_B   = 9'(NUM_BURSTS - 1);
  localparam logic [7:0]            LAST_LEN = 8'(MAX_LEN);
  localparam logic [TCW-1:0]        T_LAST   = TCW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_CMD, S_WR_DATA, S_WR_RESP, S_RD_CMD, S_RD_DATA, S_DONE
  } state_t;

  state_t                  state, state_n;
  logic [1:0]              mode_q, mode_n;
  logic [8:0]              burst_q, burst_n;
  logic [7:0]              beat_q, beat_n;
  logic [7:0]              len_q, len_n;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_n;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_n;
  logic [TCW-1:0]          tcnt_q, tcnt_n;
  logic [15:0]             err_q, err_n;
  logic                    busy_q, busy_n, done_q, done_n, pass_q, pass_n;
  logic                    tout_q, tout_n;
  logic                    valid_q, valid_n, write_q, write_n;
  logic                    wvalid_q, wvalid_n, rready_q, rready_n;
  logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_n;
  logic                    hs;

  function automatic logic [DATA_WIDTH-1:0] word(input logic [8:0] b, input logic [7:0] k);
    return SEED + (DATA_WIDTH'(b) << 8) + DATA_WIDTH'(k);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Next-state and next-output logic; every output is registered from these.
  always_comb begin
    state_n = state;
    mode_n  = mode_q;
    burst_n = burst_q;
    beat_n  = beat_q;
    len_n   = len_q;
    addr_n  = addr_q;
    tcnt_n  = tcnt_q;
    err_n   = err_q;
    busy_n  = busy_q;
    done_n  = done_q;
    pass_n  = pass_q;
    tout_n  = tout_q;
    wstrb_n = wstrb_q;
    hs      = 1'b0;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          mode_n  = (mode == 2'd3) ? 2'd0 : mode;
          err_n   = '0;
          tout_n  = 1'b0;
          pass_n  = 1'b0;
          done_n  = 1'b0;
          busy_n  = 1'b1;
          burst_n = '0;
          beat_n  = '0;
          len_n   = '0;
          addr_n  = BASE_ADDR;
          wstrb_n = '1;
          state_n = (mode == 2'd2) ? S_RD_CMD : S_WR_CMD;
        end
      end
      S_WR_CMD: begin
        if (valid_q && cmd_ready) begin
          hs      = 1'b1;
          beat_n  = '0;
          state_n = S_WR_DATA;
        end
      end
      S_WR_DATA: begin
        if (wvalid_q && cmd_wready) begin
          hs = 1'b1;
          if (beat_q == len_q) state_n = S_WR_RESP;
          else                 beat_n  = beat_q + 8'd1;
        end
      end
      S_WR_RESP: begin
        if (cmd_bvalid) begin
          hs = 1'b1;
          if (cmd_resp != 2'd0) err_n = sat_inc(err_q);
          if (burst_q != LAST_B) begin
            burst_n = burst_q + 9'd1;
            len_n   = (len_q == LAST_LEN) ? 8'd0 : len_q + 8'd1;
            addr_n  = addr_q + STRIDE;
            state_n = S_WR_CMD;
          end else if (mode_q == 2'd1) begin
            state_n = S_DONE;
          end else begin
            burst_n = '0;
            len_n   = '0;
            addr_n  = BASE_ADDR;
            state_n = S_RD_CMD;
          end
        end
      end
      S_RD_CMD: begin
        if (valid_q && cmd_ready) begin
          hs      = 1'b1;
          beat_n  = '0;
          state_n = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (rready_q && cmd_rvalid) begin
          hs = 1'b1;
          // a bad word with a bad response still counts once
          if ((cmd_rdata != word(burst_q, beat_q)) || (cmd_resp != 2'd0))
            err_n = sat_inc(err_q);
          if (beat_q != len_q) begin
            beat_n = beat_q + 8'd1;
          end else if (burst_q == LAST_B) begin
            state_n = S_DONE;
          end else begin
            burst_n = burst_q + 9'd1;
            len_n   = (len_q == LAST_LEN) ? 8'd0 : len_q + 8'd1;
            addr_n  = addr_q + STRIDE;
            state_n = S_RD_CMD;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Idle-cycle watchdog for every wait state
    if (state != S_IDLE && state != S_DONE) begin
      if (hs || state_n != state) begin
        tcnt_n = '0;
      end else if (tcnt_q == T_LAST) begin
        tcnt_n  = '0;
        tout_n  = 1'b1;
        state_n = S_DONE;
      end else begin
        tcnt_n = tcnt_q + TCW'(1);
      end
    end else begin
      tcnt_n = '0;
    end

    if (state_n == S_DONE && state != S_DONE) begin
      busy_n = 1'b0;
      done_n = 1'b1;
      pass_n = (err_n == 16'd0) && !tout_n;
    end

    valid_n  = (state_n == S_WR_CMD) || (state_n == S_RD_CMD);
    write_n  = (state_n == S_WR_CMD);
    wvalid_n = (state_n == S_WR_DATA);
    rready_n = (state_n == S_RD_DATA);
    wdata_n  = word(burst_n, beat_n);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      mode_q   <= '0;
      burst_q  <= '0;
      beat_q   <= '0;
      len_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      tcnt_q   <= '0;
      err_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      tout_q   <= 1'b0;
      valid_q  <= 1'b0;
      write_q  <= 1'b0;
      wvalid_q <= 1'b0;
      rready_q <= 1'b0;
      wstrb_q  <= '0;
    end else begin
      state    <= state_n;
      mode_q   <= mode_n;
      burst_q  <= burst_n;
      beat_q   <= beat_n;
      len_q    <= len_n;
      addr_q   <= addr_n;
      wdata_q  <= wdata_n;
      tcnt_q   <= tcnt_n;
      err_q    <= err_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
      pass_q   <= pass_n;
      tout_q   <= tout_n;
      valid_q  <= valid_n;
      write_q  <= write_n;
      wvalid_q <= wvalid_n;
      rready_q <= rready_n;
      wstrb_q  <= wstrb_n;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign timeout    = tout_q;
  assign err_count  = err_q;
  assign cmd_valid  = valid_q;
  assign cmd_write  = write_q;
  assign cmd_addr   = addr_q;
  assign cmd_len    = len_q;
  assign cmd_wvalid = wvalid_q;
  assign cmd_wdata  = wdata_q;
  assign cmd_wstrb  = wstrb_q;
  assign cmd_rready = rready_q;

endmodule
